// File: rtl/tcp_session_handler_deadlock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tcp_session_handler_deadlock_pkg
//  Description : Shared types and constants for the HLS deadlock reporter.
//                FSM state encoding, report field widths and the diagnostic
//                record layout.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package tcp_session_handler_deadlock_pkg;

  localparam int MON_ID_W   = 8;
  localparam int TS_W       = 32;
  // Widest AXIS block vector a report record can carry.
  localparam int AXIS_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REPORT = 2'd1,
    ST_HALT   = 2'd2
  } fsm_state_e;

  typedef struct packed {
    logic [MON_ID_W-1:0]   mon_id;
    logic [AXIS_MAX_W-1:0] axis_mask;
    logic [TS_W-1:0]       timestamp;
  } rpt_rec_t;

endpackage
`default_nettype wire

// File: rtl/tcp_session_handler_stall_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tcp_session_handler_stall_counter
//  Description : Counts consecutive cycles a single monitor reports `block`.
//                Saturates at THRESHOLD and flags `trip` only on the
//                THRESHOLD-th consecutive blocked cycle.
//  Ports       : clock  - clock
//                reset  - synchronous active-high reset
//                clear  - re-arm, zeroes the counter
//                block  - monitor block flag
//                trip   - combinational, high on the qualifying cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module tcp_session_handler_stall_counter #(
  parameter int THRESHOLD = 1024,
  parameter int CNT_W     = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic block,
  output logic trip
);

  localparam logic [CNT_W-1:0] c_SAT  = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(THRESHOLD - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (!block) begin
      r_cnt <= '0;
    end else if (r_cnt != c_SAT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Once saturated the counter sits at THRESHOLD, which never equals
  // THRESHOLD-1, so a stuck block does not re-trip.
  assign trip = block && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/tcp_session_handler_hls_deadlock_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : tcp_session_handler_hls_deadlock_reporter
//  Description : Qualifies HLS deadlock-monitor block flags as a deadlock once
//                one has been high for THRESHOLD consecutive cycles, captures
//                the tripping monitor, the AXIS stall flags and a timestamp,
//                and emits one report record over valid/ready.
//  Ports       : clock, reset         - clock, synchronous active-high reset
//                mon_block[NUM_MON]   - monitor block flags
//                axis_block_sigs      - AXIS stall flags sampled on trip
//                clear                - re-arm request
//                rpt_valid/rpt_ready  - report handshake
//                rpt_mon_id[8]        - tripping monitor index
//                rpt_axis_mask        - captured AXIS stall flags
//                rpt_timestamp[32]    - cycle count on the trip cycle
//                deadlock             - sticky deadlock flag
//  Revision    : 1.0 - initial release
// ============================================================================
module tcp_session_handler_hls_deadlock_reporter
  import tcp_session_handler_deadlock_pkg::*;
#(
  parameter int NUM_MON   = 1,
  parameter int NUM_AXIS  = 5,
  parameter int THRESHOLD = 1024,
  parameter int CNT_W     = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_MON-1:0]  mon_block,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic                clear,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [MON_ID_W-1:0] rpt_mon_id,
  output logic [NUM_AXIS-1:0] rpt_axis_mask,
  output logic [TS_W-1:0]     rpt_timestamp,
  output logic                deadlock
);

  localparam logic [1:0] c_S_IDLE   = ST_IDLE;
  localparam logic [1:0] c_S_REPORT = ST_REPORT;
  localparam logic [1:0] c_S_HALT   = ST_HALT;

  // Reject parameter sets the monitor id or stall counter cannot represent.
  if (NUM_MON < 1 || NUM_MON > 255 || THRESHOLD < 1 ||
      NUM_AXIS < 1 || NUM_AXIS > AXIS_MAX_W || CNT_W < 1 ||
      (CNT_W < 32 && ((64'd1 << CNT_W) <= 64'(THRESHOLD)))) begin : g_param_check
    $error("tcp_session_handler_hls_deadlock_reporter: illegal NUM_MON/NUM_AXIS/THRESHOLD/CNT_W");
  end

  logic [NUM_MON-1:0]  w_trip;
  logic                w_any_trip;
  logic [MON_ID_W-1:0] w_win_idx;
  rpt_rec_t            w_rec;

  logic [1:0]          r_state;
  logic                r_deadlock;
  logic [TS_W-1:0]     r_ts;
  rpt_rec_t            r_rec;

  for (genvar gi = 0; gi < NUM_MON; gi++) begin : g_mon
    tcp_session_handler_stall_counter #(
      .THRESHOLD (THRESHOLD),
      .CNT_W     (CNT_W)
    ) u_stall_counter (
      .clock (clock),
      .reset (reset),
      .clear (clear),
      .block (mon_block[gi]),
      .trip  (w_trip[gi])
    );
  end

  // Lowest index wins: scan downward so the last hit is the smallest.
  always_comb begin
    w_any_trip = |w_trip;
    w_win_idx  = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (w_trip[i]) begin
        w_win_idx = MON_ID_W'(i);
      end
    end
  end

  always_comb begin
    w_rec           = '0;
    w_rec.mon_id    = w_win_idx;
    w_rec.axis_mask = AXIS_MAX_W'(axis_block_sigs);
    w_rec.timestamp = r_ts;
  end

  // Free-running timestamp; clear deliberately has no effect on it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
    end
  end

  // clear outranks both a same-cycle trip and a same-cycle handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= c_S_IDLE;
      r_deadlock <= 1'b0;
      r_rec      <= '0;
    end else if (clear) begin
      r_state    <= c_S_IDLE;
      r_deadlock <= 1'b0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (w_any_trip) begin
            r_rec      <= w_rec;
            r_deadlock <= 1'b1;
            r_state    <= c_S_REPORT;
          end
        end
        c_S_REPORT: begin
          if (rpt_ready) begin
            r_state <= c_S_HALT;
          end
        end
        c_S_HALT: begin
          r_state <= c_S_HALT;
        end
        default: begin
          r_state <= c_S_IDLE;
        end
      endcase
    end
  end

  assign rpt_valid     = (r_state == c_S_REPORT);
  assign deadlock      = r_deadlock;
  assign rpt_mon_id    = r_rec.mon_id;
  assign rpt_axis_mask = r_rec.axis_mask[NUM_AXIS-1:0];
  assign rpt_timestamp = r_rec.timestamp;

endmodule
`default_nettype wire

// File: tb/tb_tcp_session_handler_hls_deadlock_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tcp_session_handler_hls_deadlock_reporter
//  Description : Self-checking bench for the HLS deadlock reporter with
//                NUM_MON=2, NUM_AXIS=5, THRESHOLD=4. A behavioural model
//                tracks run lengths, report/halt flags and the record.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tcp_session_handler_hls_deadlock_reporter;

  localparam int NUM_MON   = 2;
  localparam int NUM_AXIS  = 5;
  localparam int THRESHOLD = 4;
  localparam int CNT_W     = 16;

  logic                clock = 1'b0;
  logic                reset;
  logic [NUM_MON-1:0]  mon_block;
  logic [NUM_AXIS-1:0] axis_block_sigs;
  logic                clear;
  logic                rpt_valid;
  logic                rpt_ready;
  logic [7:0]          rpt_mon_id;
  logic [NUM_AXIS-1:0] rpt_axis_mask;
  logic [31:0]         rpt_timestamp;
  logic                deadlock;

  always #5 clock = ~clock;

  tcp_session_handler_hls_deadlock_reporter #(
    .NUM_MON   (NUM_MON),
    .NUM_AXIS  (NUM_AXIS),
    .THRESHOLD (THRESHOLD),
    .CNT_W     (CNT_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .mon_block       (mon_block),
    .axis_block_sigs (axis_block_sigs),
    .clear           (clear),
    .rpt_valid       (rpt_valid),
    .rpt_ready       (rpt_ready),
    .rpt_mon_id      (rpt_mon_id),
    .rpt_axis_mask   (rpt_axis_mask),
    .rpt_timestamp   (rpt_timestamp),
    .deadlock        (deadlock)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Behavioural model: consecutive-blocked run length per monitor, plus
  // "a report is pending" and "already reported, halted" flags.
  int          m_run [NUM_MON];
  bit          m_pending;
  bit          m_halted;
  bit          m_dead;
  bit          m_known = 1'b0;
  int unsigned m_ts;
  int unsigned m_id;
  logic [4:0]  m_mask;
  int unsigned m_rts;

  // One clock cycle: check current outputs, drive this cycle's inputs,
  // advance the model to the state expected after the next rising edge.
  task automatic step(input logic rst_i, input logic clr_i, input logic rdy_i,
                      input logic [NUM_MON-1:0] blk_i, input logic [NUM_AXIS-1:0] ax_i);
    int          first;
    int unsigned old_ts;
    @(negedge clock);
    if (m_known) begin
      check_eq("rpt_valid",     rpt_valid,     m_pending);
      check_eq("deadlock",      deadlock,      m_dead);
      check_eq("rpt_mon_id",    rpt_mon_id,    m_id);
      check_eq("rpt_axis_mask", rpt_axis_mask, m_mask);
      check_eq("rpt_timestamp", rpt_timestamp, m_rts);
    end
    reset           = rst_i;
    clear           = clr_i;
    rpt_ready       = rdy_i;
    mon_block       = blk_i;
    axis_block_sigs = ax_i;
    if (rst_i) begin
      foreach (m_run[i]) m_run[i] = 0;
      m_pending = 0; m_halted = 0; m_dead = 0;
      m_ts = 0; m_id = 0; m_mask = '0; m_rts = 0;
      m_known = 1'b1;
    end else begin
      first = -1;
      for (int i = 0; i < NUM_MON; i++) begin
        // Trip exactly when this cycle is the THRESHOLD-th consecutive one.
        if (blk_i[i] && (m_run[i] + 1 == THRESHOLD) && first < 0) first = i;
        if (clr_i || !blk_i[i]) m_run[i] = 0;
        else if (m_run[i] < THRESHOLD) m_run[i] = m_run[i] + 1;
      end
      old_ts = m_ts;
      m_ts   = m_ts + 1;
      if (clr_i) begin
        m_pending = 0; m_halted = 0; m_dead = 0;
      end else if (!m_pending && !m_halted) begin
        if (first >= 0) begin
          m_id = first; m_mask = ax_i; m_rts = old_ts;
          m_pending = 1; m_dead = 1;
        end
      end else if (m_pending && rdy_i) begin
        m_pending = 0; m_halted = 1;
      end
    end
  endtask

  initial begin
    logic [NUM_MON-1:0] r_blk;
    reset = 1'b1; clear = 1'b0; rpt_ready = 1'b0;
    mon_block = '0; axis_block_sigs = '0;

    repeat (2) step(1, 0, 0, 2'b00, 5'd0);

    // Scenario 1: monitor 0 blocked for cycles 10..13.
    repeat (10) step(0, 0, 1, 2'b00, 5'd0);
    repeat (4)  step(0, 0, 1, 2'b01, 5'b00100);
    step(0, 0, 1, 2'b00, 5'd0);
    check_eq("s1_valid", rpt_valid, 1);
    check_eq("s1_id",    rpt_mon_id, 0);
    check_eq("s1_mask",  rpt_axis_mask, 5'b00100);
    check_eq("s1_ts",    rpt_timestamp, 13);
    repeat (5) step(0, 0, 1, 2'b00, 5'd0);
    check_eq("s1_valid_after", rpt_valid, 0);
    check_eq("s1_dead_after",  deadlock, 1);

    // Scenario 2: broken run never reaches the threshold.
    step(0, 1, 1, 2'b00, 5'd0);
    repeat (3) step(0, 0, 1, 2'b10, 5'd3);
    step(0, 0, 1, 2'b00, 5'd3);
    repeat (3) step(0, 0, 1, 2'b10, 5'd3);
    repeat (2) step(0, 0, 1, 2'b00, 5'd0);
    check_eq("s2_valid", rpt_valid, 0);
    check_eq("s2_dead",  deadlock, 0);

    // Scenario 3: simultaneous trip, lowest index wins, HALT ignores more.
    step(0, 1, 1, 2'b00, 5'd0);
    repeat (4)  step(0, 0, 1, 2'b11, 5'b10001);
    repeat (10) step(0, 0, 1, 2'b10, 5'b01010);
    check_eq("s3_id",    rpt_mon_id, 0);
    check_eq("s3_valid", rpt_valid, 0);
    check_eq("s3_dead",  deadlock, 1);

    // Scenario 4: back-pressure holds the record.
    step(0, 1, 1, 2'b00, 5'd0);
    repeat (4) step(0, 0, 0, 2'b01, 5'b11011);
    repeat (6) step(0, 0, 0, 2'b01, 5'b00000);
    step(0, 0, 1, 2'b01, 5'b00000);
    repeat (2) step(0, 0, 1, 2'b00, 5'd0);

    // Scenario 5: clear during REPORT with a same-cycle handshake.
    step(0, 1, 1, 2'b00, 5'd0);
    repeat (4) step(0, 0, 0, 2'b01, 5'b00110);
    step(0, 0, 0, 2'b01, 5'd0);
    step(0, 1, 1, 2'b01, 5'd0);
    step(0, 0, 0, 2'b01, 5'b11100);
    check_eq("s5_valid_clr", rpt_valid, 0);
    check_eq("s5_dead_clr",  deadlock, 0);
    repeat (8) step(0, 0, 0, 2'b01, 5'b11100);

    // Scenario 6: reset while a report is pending.
    step(0, 1, 1, 2'b00, 5'd0);
    repeat (4) step(0, 0, 0, 2'b10, 5'b01111);
    step(0, 0, 0, 2'b10, 5'd0);
    step(1, 0, 0, 2'b10, 5'd0);
    step(0, 0, 0, 2'b00, 5'd0);
    check_eq("s6_valid", rpt_valid, 0);
    check_eq("s6_dead",  deadlock, 0);
    check_eq("s6_ts",    rpt_timestamp, 0);
    check_eq("s6_id",    rpt_mon_id, 0);

    // Timestamp wrap: preload the counter just below the wrap point.
    step(0, 1, 1, 2'b00, 5'd0);
    force dut.r_ts = 32'hFFFF_FFFC;
    #1;
    release dut.r_ts;
    m_ts = 32'hFFFF_FFFD;
    repeat (4) step(0, 0, 0, 2'b01, 5'b10101);
    step(0, 0, 0, 2'b00, 5'd0);
    check_eq("wrap_valid", rpt_valid, 1);
    check_eq("wrap_ts",    rpt_timestamp, 0);
    step(0, 0, 1, 2'b00, 5'd0);

    // Randomized phase: sticky block patterns so runs reach the threshold.
    r_blk = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NUM_MON; b++) begin
        if ($urandom_range(0, 7) == 0) r_blk[b] = ~r_blk[b];
      end
      step(logic'($urandom_range(0, 299) == 0),
           logic'($urandom_range(0, 59) == 0),
           logic'($urandom_range(0, 2) != 0),
           r_blk,
           NUM_AXIS'($urandom));
    end
    step(0, 0, 1, 2'b00, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
